// File: rtl/sram_arbiter_if.sv
// CPU-side request/ack signals and the asynchronous SRAM pin bundle for sram_arbiter.
// The slave modport is the arbiter's view; the master modport is the CPU/board view.
interface sram_arbiter_if #(
  parameter int SRAM_AW = 20
);
  logic               if_ce_i;
  logic [31:0]        if_addr_i;
  logic [31:0]        if_data_o;
  logic               if_ack_o;
  logic               if_stallreq_o;
  logic               d_ce_i;
  logic               d_we_i;
  logic [3:0]         d_sel_i;
  logic [31:0]        d_addr_i;
  logic [31:0]        d_data_i;
  logic [31:0]        d_data_o;
  logic               d_ack_o;
  logic               d_stallreq_o;
  logic [SRAM_AW-1:0] sram_addr_o;
  logic [31:0]        sram_data_i;
  logic [31:0]        sram_data_o;
  logic               sram_data_oe_o;
  logic               sram_ce_n_o;
  logic               sram_oe_n_o;
  logic               sram_we_n_o;
  logic [3:0]         sram_be_n_o;

  modport slave (
    input  if_ce_i, if_addr_i, d_ce_i, d_we_i, d_sel_i, d_addr_i, d_data_i, sram_data_i,
    output if_data_o, if_ack_o, if_stallreq_o, d_data_o, d_ack_o, d_stallreq_o,
    output sram_addr_o, sram_data_o, sram_data_oe_o, sram_ce_n_o, sram_oe_n_o,
    output sram_we_n_o, sram_be_n_o
  );

  modport master (
    output if_ce_i, if_addr_i, d_ce_i, d_we_i, d_sel_i, d_addr_i, d_data_i, sram_data_i,
    input  if_data_o, if_ack_o, if_stallreq_o, d_data_o, d_ack_o, d_stallreq_o,
    input  sram_addr_o, sram_data_o, sram_data_oe_o, sram_ce_n_o, sram_oe_n_o,
    input  sram_we_n_o, sram_be_n_o
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between the fetch and data ports: fixed data priority,
// fixed-length accesses, one-cycle ack pulses and per-port stall requests.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int SRAM_AW       = 20
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state;
  logic               owner_d;
  logic [3:0]         cnt;
  logic               ce_n;
  logic               oe_n;
  logic               we_n;
  logic               data_oe;
  logic [3:0]         be_n;
  logic [SRAM_AW-1:0] addr;
  logic [31:0]        wdata;
  logic [31:0]        if_data;
  logic [31:0]        d_data;
  logic               if_ack;
  logic               d_ack;
  logic               unused_addr_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      cnt     <= 4'd0;
      ce_n    <= 1'b1;
      oe_n    <= 1'b1;
      we_n    <= 1'b1;
      be_n    <= 4'b1111;
      data_oe <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      if_data <= '0;
      d_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.d_ce_i) begin
            owner_d <= 1'b1;
            addr    <= bus.d_addr_i[SRAM_AW+1:2];
            wdata   <= bus.d_data_i;
            ce_n    <= 1'b0;
            oe_n    <= bus.d_we_i;
            we_n    <= ~bus.d_we_i;
            data_oe <= bus.d_we_i;
            be_n    <= bus.d_we_i ? ~bus.d_sel_i : 4'b0000;
            cnt     <= 4'(ACCESS_CYCLES - 1);
            state   <= ACCESS;
          end else if (bus.if_ce_i) begin
            owner_d <= 1'b0;
            addr    <= bus.if_addr_i[SRAM_AW+1:2];
            ce_n    <= 1'b0;
            oe_n    <= 1'b0;
            we_n    <= 1'b1;
            data_oe <= 1'b0;
            be_n    <= 4'b0000;
            cnt     <= 4'(ACCESS_CYCLES - 1);
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            // we_n high means this was a read: capture while oe_n is still asserted
            if (we_n) begin
              if (owner_d) d_data  <= bus.sram_data_i;
              else         if_data <= bus.sram_data_i;
            end
            ce_n    <= 1'b1;
            oe_n    <= 1'b1;
            we_n    <= 1'b1;
            be_n    <= 4'b1111;
            data_oe <= 1'b0;
            state   <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A requester that withdrew during the access (flush) gets no ack
  assign if_ack = (state == DONE) && !owner_d && bus.if_ce_i;
  assign d_ack  = (state == DONE) &&  owner_d && bus.d_ce_i;

  assign bus.if_ack_o       = if_ack;
  assign bus.d_ack_o        = d_ack;
  assign bus.if_stallreq_o  = bus.if_ce_i & ~if_ack;
  assign bus.d_stallreq_o   = bus.d_ce_i & ~d_ack;
  assign bus.if_data_o      = if_data;
  assign bus.d_data_o       = d_data;
  assign bus.sram_addr_o    = addr;
  assign bus.sram_data_o    = wdata;
  assign bus.sram_data_oe_o = data_oe;
  assign bus.sram_ce_n_o    = ce_n;
  assign bus.sram_oe_n_o    = oe_n;
  assign bus.sram_we_n_o    = we_n;
  assign bus.sram_be_n_o    = be_n;

  assign unused_addr_bits = ^{bus.if_addr_i[31:SRAM_AW+2], bus.if_addr_i[1:0],
                              bus.d_addr_i[31:SRAM_AW+2], bus.d_addr_i[1:0]};
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: per-cycle vector table on a 2-cycle instance,
// plus a hand-written back-to-back read sequence on a 1-cycle instance.
module tb_sram_arbiter;
  localparam logic [31:0] WA = 32'h3C011234;
  localparam logic [31:0] WB = 32'h24020005;
  localparam logic [31:0] WD = 32'h8C430000;
  localparam logic [31:0] WC = 32'h0000CCDD;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  logic [31:0] mem [256];

  sram_arbiter_if #(.SRAM_AW(20)) bus0 ();
  sram_arbiter_if #(.SRAM_AW(20)) bus1 ();

  sram_arbiter #(.ACCESS_CYCLES(2), .SRAM_AW(20)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  sram_arbiter #(.ACCESS_CYCLES(1), .SRAM_AW(20)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM: drives valid data only while selected and output-enabled
  assign bus0.sram_data_i = (!bus0.sram_ce_n_o && !bus0.sram_oe_n_o) ?
                            mem[bus0.sram_addr_o[7:0]] : 32'hDEADBEEF;
  assign bus1.sram_data_i = (!bus1.sram_ce_n_o && !bus1.sram_oe_n_o) ?
                            mem[bus1.sram_addr_o[7:0]] : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[4] <= WA;
      mem[5] <= WB;
      mem[6] <= WD;
    end else if (!bus0.sram_ce_n_o && !bus0.sram_we_n_o && bus0.sram_data_oe_o) begin
      for (int b = 0; b < 4; b++)
        if (!bus0.sram_be_n_o[b])
          mem[bus0.sram_addr_o[7:0]][8*b +: 8] <= bus0.sram_data_o[8*b +: 8];
    end
  end

  typedef struct packed {
    logic        iack, dack, istall, dstall, ce_n, oe_n, we_n;
    logic [3:0]  be_n;
    logic        doe;
    logic [19:0] saddr;
    logic [31:0] sdo, idata, ddata;
  } obs_t;

  typedef struct {
    logic        rst, ice;
    logic [31:0] iaddr;
    logic        dce, dwe;
    logic [3:0]  sel;
    logic [31:0] daddr, dwd;
    obs_t        mask;
    obs_t        exp;
  } vec_t;

  vec_t vecs[$];

  // mode: 0 = bus idle, 1 = read access, 2 = write access
  task automatic add(input logic [31:0] r, i, ia, d, w, s, da, dw, input int mode,
                     input logic [31:0] be, sa, sdo, iak, dak, idat, ddat);
    vec_t v;
    v.rst = 1'(r);  v.ice = 1'(i);  v.iaddr = ia;
    v.dce = 1'(d);  v.dwe = 1'(w);  v.sel = 4'(s);
    v.daddr = da;   v.dwd = dw;
    v.mask = '1;
    v.exp.iack   = 1'(iak);
    v.exp.dack   = 1'(dak);
    v.exp.istall = 1'(i) & ~1'(iak);
    v.exp.dstall = 1'(d) & ~1'(dak);
    v.exp.idata  = idat;
    v.exp.ddata  = ddat;
    v.exp.saddr  = 20'(sa);
    v.exp.sdo    = sdo;
    case (mode)
      1: begin
        {v.exp.ce_n, v.exp.oe_n, v.exp.we_n, v.exp.be_n, v.exp.doe} = {3'b001, 4'b0000, 1'b0};
        v.mask.sdo = '0;
      end
      2: begin
        {v.exp.ce_n, v.exp.oe_n, v.exp.we_n, v.exp.be_n, v.exp.doe} = {3'b010, 4'(be), 1'b1};
      end
      default: begin
        {v.exp.ce_n, v.exp.oe_n, v.exp.we_n, v.exp.be_n, v.exp.doe} = {3'b111, 4'b1111, 1'b0};
        v.mask.sdo   = '0;
        v.mask.saddr = '0;
      end
    endcase
    vecs.push_back(v);
  endtask

  function automatic obs_t sample0();
    obs_t o;
    o.iack = bus0.if_ack_o;        o.dack = bus0.d_ack_o;
    o.istall = bus0.if_stallreq_o; o.dstall = bus0.d_stallreq_o;
    o.ce_n = bus0.sram_ce_n_o;     o.oe_n = bus0.sram_oe_n_o;
    o.we_n = bus0.sram_we_n_o;     o.be_n = bus0.sram_be_n_o;
    o.doe = bus0.sram_data_oe_o;   o.saddr = bus0.sram_addr_o;
    o.sdo = bus0.sram_data_o;      o.idata = bus0.if_data_o;
    o.ddata = bus0.d_data_o;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic unused_tb;
  assign unused_tb = ^{bus0.sram_addr_o[19:8], bus1.sram_addr_o[19:8], bus1.if_data_o,
                       bus1.if_ack_o, bus1.if_stallreq_o, bus1.sram_data_o,
                       bus1.sram_data_oe_o, bus1.sram_we_n_o, bus1.sram_be_n_o};

  initial begin
    logic [31:0] raddr [3];
    logic [31:0] rdata [3];
    obs_t act;
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    {bus0.if_ce_i, bus0.if_addr_i, bus0.d_ce_i, bus0.d_we_i} = '0;
    {bus0.d_sel_i, bus0.d_addr_i, bus0.d_data_i} = '0;
    {bus1.if_ce_i, bus1.if_addr_i, bus1.d_ce_i, bus1.d_we_i} = '0;
    {bus1.d_sel_i, bus1.d_addr_i, bus1.d_data_i} = '0;

    //  rst ice iaddr  dce dwe sel daddr         wdata          mode be  saddr  sdo           iak dak idata ddata
    add(1, 0, 0,     0, 0, 0,   0,            0,            0, 0,   0,     0,            0, 0, 0,  0);
    // fetch only
    add(0, 1, 'h10,  0, 0, 0,   0,            0,            0, 0,   0,     0,            0, 0, 0,  0);
    add(0, 1, 'h10,  0, 0, 0,   0,            0,            1, 0,   4,     0,            0, 0, 0,  0);
    add(0, 1, 'h10,  0, 0, 0,   0,            0,            1, 0,   4,     0,            0, 0, 0,  0);
    add(0, 1, 'h10,  0, 0, 0,   0,            0,            0, 0,   0,     0,            1, 0, WA, 0);
    add(0, 0, 0,     0, 0, 0,   0,            0,            0, 0,   0,     0,            0, 0, WA, 0);
    // write, with request fields changing mid-access
    add(0, 0, 0,     1, 1, 3,   'h100,        'hAABBCCDD,   0, 0,   0,     0,            0, 0, WA, 0);
    add(0, 0, 0,     1, 1, 3,   'h100,        'hAABBCCDD,   2, 'hC, 'h40,  'hAABBCCDD,   0, 0, WA, 0);
    add(0, 0, 0,     1, 1, 'hF, 'h200,        'h11111111,   2, 'hC, 'h40,  'hAABBCCDD,   0, 0, WA, 0);
    add(0, 0, 0,     1, 1, 'hF, 'h200,        'h11111111,   0, 0,   0,     0,            0, 1, WA, 0);
    add(0, 0, 0,     0, 0, 0,   0,            0,            0, 0,   0,     0,            0, 0, WA, 0);
    // read back
    add(0, 0, 0,     1, 0, 'hF, 'h100,        0,            0, 0,   0,     0,            0, 0, WA, 0);
    add(0, 0, 0,     1, 0, 'hF, 'h100,        0,            1, 0,   'h40,  0,            0, 0, WA, 0);
    add(0, 0, 0,     1, 0, 'hF, 'h100,        0,            1, 0,   'h40,  0,            0, 0, WA, 0);
    add(0, 0, 0,     1, 0, 'hF, 'h100,        0,            0, 0,   0,     0,            0, 1, WA, WC);
    add(0, 0, 0,     0, 0, 0,   0,            0,            0, 0,   0,     0,            0, 0, WA, WC);
    // simultaneous requests: data first, then fetch
    add(0, 1, 'h14,  1, 0, 'hF, 'h10,         0,            0, 0,   0,     0,            0, 0, WA, WC);
    add(0, 1, 'h14,  1, 0, 'hF, 'h10,         0,            1, 0,   4,     0,            0, 0, WA, WC);
    add(0, 1, 'h14,  1, 0, 'hF, 'h10,         0,            1, 0,   4,     0,            0, 0, WA, WC);
    add(0, 1, 'h14,  1, 0, 'hF, 'h10,         0,            0, 0,   0,     0,            0, 1, WA, WA);
    add(0, 1, 'h14,  0, 0, 0,   0,            0,            0, 0,   0,     0,            0, 0, WA, WA);
    add(0, 1, 'h14,  0, 0, 0,   0,            0,            1, 0,   5,     0,            0, 0, WA, WA);
    add(0, 1, 'h14,  0, 0, 0,   0,            0,            1, 0,   5,     0,            0, 0, WA, WA);
    add(0, 1, 'h14,  0, 0, 0,   0,            0,            0, 0,   0,     0,            1, 0, WB, WA);
    add(0, 0, 0,     0, 0, 0,   0,            0,            0, 0,   0,     0,            0, 0, WB, WA);
    // fetch flushed after grant
    add(0, 1, 'h10,  0, 0, 0,   0,            0,            0, 0,   0,     0,            0, 0, WB, WA);
    add(0, 0, 0,     0, 0, 0,   0,            0,            1, 0,   4,     0,            0, 0, WB, WA);
    add(0, 0, 0,     0, 0, 0,   0,            0,            1, 0,   4,     0,            0, 0, WB, WA);
    add(0, 0, 0,     0, 0, 0,   0,            0,            0, 0,   0,     0,            0, 0, WA, WA);
    add(0, 0, 0,     1, 0, 'hF, 'h14,         0,            0, 0,   0,     0,            0, 0, WA, WA);
    add(0, 0, 0,     1, 0, 'hF, 'h14,         0,            1, 0,   5,     0,            0, 0, WA, WA);
    add(0, 0, 0,     1, 0, 'hF, 'h14,         0,            1, 0,   5,     0,            0, 0, WA, WA);
    add(0, 0, 0,     1, 0, 'hF, 'h14,         0,            0, 0,   0,     0,            0, 1, WA, WB);
    add(0, 0, 0,     0, 0, 0,   0,            0,            0, 0,   0,     0,            0, 0, WA, WB);
    // reset in the first cycle of a write
    add(0, 0, 0,     1, 1, 'hF, 'h20,         'h55AA55AA,   0, 0,   0,     0,            0, 0, WA, WB);
    add(1, 0, 0,     1, 1, 'hF, 'h20,         'h55AA55AA,   2, 0,   8,     'h55AA55AA,   0, 0, WA, WB);
    add(0, 0, 0,     0, 0, 0,   0,            0,            0, 0,   0,     0,            0, 0, 0,  0);
    add(0, 0, 0,     0, 0, 0,   0,            0,            0, 0,   0,     0,            0, 0, 0,  0);
    add(0, 0, 0,     1, 0, 'hF, 'h10,         0,            0, 0,   0,     0,            0, 0, 0,  0);
    add(0, 0, 0,     1, 0, 'hF, 'h10,         0,            1, 0,   4,     0,            0, 0, 0,  0);
    add(0, 0, 0,     1, 0, 'hF, 'h10,         0,            1, 0,   4,     0,            0, 0, 0,  0);
    add(0, 0, 0,     1, 0, 'hF, 'h10,         0,            0, 0,   0,     0,            0, 1, 0,  WA);
    add(0, 0, 0,     0, 0, 0,   0,            0,            0, 0,   0,     0,            0, 0, 0,  WA);
    // write with no byte enables, then read with junk upper/lower address bits
    add(0, 0, 0,     1, 1, 0,   'h14,         'hFFFFFFFF,   0, 0,   0,     0,            0, 0, 0,  WA);
    add(0, 0, 0,     1, 1, 0,   'h14,         'hFFFFFFFF,   2, 'hF, 5,     'hFFFFFFFF,   0, 0, 0,  WA);
    add(0, 0, 0,     1, 1, 0,   'h14,         'hFFFFFFFF,   2, 'hF, 5,     'hFFFFFFFF,   0, 0, 0,  WA);
    add(0, 0, 0,     1, 1, 0,   'h14,         'hFFFFFFFF,   0, 0,   0,     0,            0, 1, 0,  WA);
    add(0, 0, 0,     0, 0, 0,   0,            0,            0, 0,   0,     0,            0, 0, 0,  WA);
    add(0, 0, 0,     1, 0, 'hF, 'hFFC00017,   0,            0, 0,   0,     0,            0, 0, 0,  WA);
    add(0, 0, 0,     1, 0, 'hF, 'hFFC00017,   0,            1, 0,   5,     0,            0, 0, 0,  WA);
    add(0, 0, 0,     1, 0, 'hF, 'hFFC00017,   0,            1, 0,   5,     0,            0, 0, 0,  WA);
    add(0, 0, 0,     1, 0, 'hF, 'hFFC00017,   0,            0, 0,   0,     0,            0, 1, 0,  WB);
    add(0, 0, 0,     0, 0, 0,   0,            0,            0, 0,   0,     0,            0, 0, 0,  WB);

    repeat (2) @(posedge clk);
    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].rst;
      bus0.if_ce_i  = vecs[k].ice;  bus0.if_addr_i = vecs[k].iaddr;
      bus0.d_ce_i   = vecs[k].dce;  bus0.d_we_i    = vecs[k].dwe;
      bus0.d_sel_i  = vecs[k].sel;  bus0.d_addr_i  = vecs[k].daddr;
      bus0.d_data_i = vecs[k].dwd;
      #1;
      act = sample0();
      nvec++;
      if ((act & vecs[k].mask) !== (vecs[k].exp & vecs[k].mask)) begin
        nerr++;
        $display("FAIL vec%0d: got %h expected %h (mask %h)", k, act, vecs[k].exp, vecs[k].mask);
      end
    end

    // one-cycle accesses: held request, new address after each ack
    raddr[0] = 32'h10; raddr[1] = 32'h14; raddr[2] = 32'h18;
    rdata[0] = WA;     rdata[1] = WB;     rdata[2] = WD;
    @(negedge clk);
    bus1.d_ce_i = 1'b1; bus1.d_we_i = 1'b0; bus1.d_sel_i = 4'hF; bus1.d_addr_i = raddr[0];
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) begin
        #1;
        chk($sformatf("b2b%0d_c%0d_ack", k, c), 32'(bus1.d_ack_o), 32'(c == 2));
        chk($sformatf("b2b%0d_c%0d_stall", k, c), 32'(bus1.d_stallreq_o), 32'(c != 2));
        if (c == 1) begin
          chk($sformatf("b2b%0d_addr", k), 32'(bus1.sram_addr_o), raddr[k] >> 2);
          chk($sformatf("b2b%0d_ce_n", k), 32'(bus1.sram_ce_n_o), 32'd0);
        end
        if (c == 2) chk($sformatf("b2b%0d_data", k), bus1.d_data_o, rdata[k]);
        @(negedge clk);
        if (c == 2) begin
          if (k < 2) bus1.d_addr_i = raddr[k+1];
          else       bus1.d_ce_i = 1'b0;
        end
      end
    end
    #1;
    chk("b2b_idle_ce_n", 32'(bus1.sram_ce_n_o), 32'd1);
    chk("b2b_idle_ack", 32'(bus1.d_ack_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences a single shared asynchronous SRAM between two requesters: the instruction-fetch port (pc_reg/if_id side) and the data port (mem stage side) of the CPU.
- Converts each level-held request into a fixed-length, multi-cycle SRAM access.
- Returns read data with a one-cycle ack pulse.
- Produces per-port stall requests for ctrl, so the pipeline freezes until the access completes.

Parameters:
- ACCESS_CYCLES, 2, number of cycles the SRAM controls are held active per access; legal range 1..15.
- SRAM_AW, 20, SRAM word-address width; CPU byte address bits [SRAM_AW+1:2] are used.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_ce_i  in  1  fetch request, held until if_ack_o.
- if_addr_i  in  32  fetch byte address.
- if_data_o  out  32  fetched word, valid when if_ack_o=1, held until the next fetch ack.
- if_ack_o  out  1  one-cycle completion pulse for fetch.
- if_stallreq_o  out  1  fetch stall request to ctrl.
- d_ce_i  in  1  data request, held until d_ack_o.
- d_we_i  in  1  1 = write, 0 = read.
- d_sel_i  in  4  byte enables, active high.
- d_addr_i  in  32  data byte address.
- d_data_i  in  32  write data.
- d_data_o  out  32  read word, valid when d_ack_o=1, held until the next data ack.
- d_ack_o  out  1  one-cycle completion pulse for data.
- d_stallreq_o  out  1  data stall request to ctrl.
- sram_addr_o  out  SRAM_AW  word address.
- sram_data_i  in  32  SRAM read bus.
- sram_data_o  out  32  SRAM write bus.
- sram_data_oe_o  out  1  write-bus drive enable.
- sram_ce_n_o  out  1  chip enable, active low.
- sram_oe_n_o  out  1  output enable, active low.
- sram_we_n_o  out  1  write enable, active low.
- sram_be_n_o  out  4  byte enables, active low.

Behaviour:
- Reset (rst=1 at an edge), all of the following take effect at that edge:
  - state = IDLE, owner cleared, counter = 0.
  - sram_ce_n_o = sram_oe_n_o = sram_we_n_o = 1, sram_be_n_o = 4'b1111, sram_data_oe_o = 0.
  - sram_addr_o = 0, sram_data_o = 0.
  - if_data_o = d_data_o = 0, both acks = 0.
  - Any in-flight access is abandoned with no ack.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If d_ce_i=1: grant data (fixed priority: data > fetch). Else if if_ce_i=1: grant fetch. Else stay.
  - On grant, register address, write data, we and sel into the SRAM outputs; go to ACCESS; counter = ACCESS_CYCLES-1.
- ACCESS (cycles 1..ACCESS_CYCLES after grant):
  - sram_ce_n_o = 0.
  - Read: sram_oe_n_o = 0, sram_we_n_o = 1, sram_data_oe_o = 0, sram_be_n_o = 4'b0000.
  - Write: sram_we_n_o = 0, sram_oe_n_o = 1, sram_data_oe_o = 1, sram_be_n_o = ~d_sel_i as latched at grant.
  - Counter decrements each cycle. At counter = 0, on the next edge:
    - For reads, sram_data_i is captured into the owner's data_o register.
    - State goes to DONE and all SRAM controls return to their reset values.
- DONE (one cycle):
  - The owner's ack = 1 only if its ce_i is still 1. A withdrawn request (pipeline flush) completes silently with no ack; its data_o is still updated.
  - Next state is IDLE. DONE serves as the bus-turnaround cycle.
- Latency: grant cycle t, ack at t+ACCESS_CYCLES+1; the next grant is no earlier than t+ACCESS_CYCLES+2.
- Stalls (combinational): if_stallreq_o = if_ce_i & ~if_ack_o; d_stallreq_o = d_ce_i & ~d_ack_o.
- Simultaneous requests: data is served first; fetch stays stalled and is granted in the IDLE after data DONE if if_ce_i is still 1.
- Fetch cannot starve: each data access belongs to an instruction already fetched, and the mem stage drops d_ce_i after its ack.
- Requests are sampled only in IDLE. Changes to addr/we/sel/data after grant have no effect on the current access.
- A write with d_sel_i = 0000 performs a full cycle with sram_be_n_o = 1111 and still acks.
- Address bits [1:0] and bits above SRAM_AW+1 are ignored.

Test Plan:
- ACCESS_CYCLES=2, fetch only: if_ce_i=1, if_addr_i=0x00000010, SRAM returns 0x3C011234 → sram_addr_o=4; oe_n low for cycles t+1..t+2; if_ack_o pulses at t+3 with if_data_o=0x3C011234; if_stallreq_o high t..t+2, low at t+3.
- Data write then read: write addr 0x100, sel=4'b0011, data 0xAABBCCDD → we_n low 2 cycles, be_n=4'b1100, data_oe=1, d_ack at t+3. Then read 0x100 with a modelled SRAM → d_data_o=0x0000CCDD.
- Simultaneous: if_ce_i and d_ce_i both rise in the same IDLE cycle → data granted first (ack t+3); fetch granted at t+4, if_ack_o at t+7.
- Flush: fetch granted, if_ce_i dropped at t+1 → access runs to completion, no if_ack_o at t+3, state returns to IDLE at t+4.
- Reset mid-access: rst=1 at t+1 of a write → at the next edge all SRAM controls inactive, no d_ack_o; after reset, a new read completes normally.
- ACCESS_CYCLES=1, back-to-back data reads holding d_ce_i with a new address after each ack → one ack every 3 cycles, correct data each time.
